// File: rtl/hycube_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hycube_arb_pkg
// Description : Shared constants and index helpers for router output arbiters.
// Revision    : 1.0 - initial release
// ============================================================================
package hycube_arb_pkg;

    localparam int MAX_ARB_INPUTS = 16;

    localparam int DIR_N  = 0;
    localparam int DIR_E  = 1;
    localparam int DIR_S  = 2;
    localparam int DIR_W  = 3;
    localparam int DIR_PE = 4;

    // Explicit compare so non-power-of-two input counts wrap correctly.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_output_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_output_arbiter_if
// Description : Upstream FIFO bank and downstream link bundle for the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_output_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_INPUTS = 5,
    parameter int IDX_WIDTH  = $clog2(NUM_INPUTS)
);
    logic [NUM_INPUTS-1:0]                 ia__data_in_valid;
    logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] ia__data_in;
    logic [NUM_INPUTS-1:0]                 oa__data_in_ready;
    logic [NUM_INPUTS-1:0]                 ia__input_enable;
    logic                                  o__data_out_valid;
    logic [DATA_WIDTH-1:0]                 o__data_out;
    logic [IDX_WIDTH-1:0]                  o__data_out_src;
    logic                                  i__data_out_ready;
    logic                                  i__clear_all;

    modport slave (
        input  ia__data_in_valid, ia__data_in, ia__input_enable,
        input  i__data_out_ready, i__clear_all,
        output oa__data_in_ready, o__data_out_valid, o__data_out, o__data_out_src
    );

    modport master (
        output ia__data_in_valid, ia__data_in, ia__input_enable,
        output i__data_out_ready, i__clear_all,
        input  oa__data_in_ready, o__data_out_valid, o__data_out, o__data_out_src
    );
endinterface
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_picker
// Description : Combinational round-robin find-first starting at ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_picker
    import hycube_arb_pkg::*;
#(
    parameter int NUM_INPUTS = 5,
    parameter int IDX_WIDTH  = $clog2(NUM_INPUTS)
) (
    input  wire logic [NUM_INPUTS-1:0] req,
    input  wire logic [IDX_WIDTH-1:0]  ptr,
    output logic                       grant_valid,
    output logic [IDX_WIDTH-1:0]       grant_idx
);

    localparam int c_dbl_w = 2 * NUM_INPUTS;

    logic [c_dbl_w-1:0] w_dbl_req;
    logic [c_dbl_w-1:0] w_masked;
    int                 w_first;

    assign w_dbl_req = {req, req};

    // Lower copy keeps only indices at or above ptr; upper copy supplies the wrap.
    for (genvar j = 0; j < c_dbl_w; j++) begin : g_mask
        if (j >= NUM_INPUTS) begin : g_hi
            assign w_masked[j] = w_dbl_req[j];
        end else begin : g_lo
            assign w_masked[j] = w_dbl_req[j] & (ptr <= IDX_WIDTH'(j));
        end
    end

    always_comb begin
        w_first = 0;
        for (int j = c_dbl_w - 1; j >= 0; j--) begin
            if (w_masked[j]) begin
                w_first = j;
            end
        end
    end

    assign grant_valid = |req;
    assign grant_idx   = (w_first >= NUM_INPUTS) ? IDX_WIDTH'(w_first - NUM_INPUTS)
                                                 : IDX_WIDTH'(w_first);

endmodule
`default_nettype wire

// File: rtl/rr_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_output_arbiter
// Description : Round-robin N-to-1 arbiter with a registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_output_arbiter
    import hycube_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_INPUTS = 5,
    parameter int IDX_WIDTH  = $clog2(NUM_INPUTS)
) (
    input  wire logic         clk,
    input  wire logic         reset,
    rr_output_arbiter_if.slave bus
);

    logic [IDX_WIDTH-1:0]  r__ptr;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [IDX_WIDTH-1:0]  r_out_src;

    logic [NUM_INPUTS-1:0] w_req;
    logic                  w_grant_valid;
    logic [IDX_WIDTH-1:0]  w_grant_idx;
    logic                  w_load;
    logic [NUM_INPUTS-1:0] w_ready;

    assign w_req = bus.ia__data_in_valid & bus.ia__input_enable;

    rr_priority_picker #(
        .NUM_INPUTS (NUM_INPUTS),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_picker (
        .req         (w_req),
        .ptr         (r__ptr),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    assign w_load = (!r_out_valid || bus.i__data_out_ready) && w_grant_valid;

    // Pop is suppressed by flush and reset so no word is lost upstream.
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ready
        assign w_ready[i] = w_load && !bus.i__clear_all && !reset
                            && (w_grant_idx == IDX_WIDTH'(i));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r__ptr      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else if (bus.i__clear_all) begin
            r__ptr      <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= bus.ia__data_in[w_grant_idx];
            r_out_src   <= w_grant_idx;
            r__ptr      <= IDX_WIDTH'(wrap_inc(32'(w_grant_idx), NUM_INPUTS));
        end else if (r_out_valid && bus.i__data_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.oa__data_in_ready = w_ready;
    assign bus.o__data_out_valid = r_out_valid;
    assign bus.o__data_out       = r_out_data;
    assign bus.o__data_out_src   = r_out_src;

endmodule
`default_nettype wire

// File: doc/rr_output_arbiter.md
# rr_output_arbiter

Round-robin N-to-1 arbiter with a registered output stage. It sits directly downstream of a bank of first-word fall-through bypass FIFOs, one per router input direction, and merges their valid/ready streams onto a single output link toward the next router hop or the PE operand port. Fairness is strict round-robin over the enabled inputs. The registered output stage sustains one transfer per cycle.

## Interface
Parameters:
- DATA_WIDTH, 64, payload width.
- NUM_INPUTS, 5, number of upstream FIFOs (N, E, S, W, PE); legal range 2..16.
- IDX_WIDTH, $clog2(NUM_INPUTS), width of the source index (derived; do not override).

Ports:
- clk  input  1  single clock; all state is updated on the rising edge.
- reset  input  1  synchronous, active-high.
- ia__data_in_valid  input  [NUM_INPUTS]  per-input valid, driven by the FIFO output valid.
- ia__data_in  input  [DATA_WIDTH] x NUM_INPUTS  per-input payload.
- oa__data_in_ready  output  [NUM_INPUTS]  per-input pop; at most one bit is high per cycle.
- ia__input_enable  input  [NUM_INPUTS]  configuration mask; a disabled input is never granted.
- o__data_out_valid  output  1  output register holds valid data.
- o__data_out  output  DATA_WIDTH  registered payload.
- o__data_out_src  output  IDX_WIDTH  index of the input that supplied o__data_out.
- i__data_out_ready  input  1  downstream accepts this cycle.
- i__clear_all  input  1  synchronous flush.

## Operation
- State:
  - r__ptr (IDX_WIDTH bits), the highest-priority index.
  - The output register, holding valid, data and src.
- Request vector: req = ia__data_in_valid & ia__input_enable.
- Grant: g is the first index with req set, searching r__ptr, r__ptr+1, … with wrap-around modulo NUM_INPUTS. The search is purely combinational.
- load = (o__data_out_valid == 0 || i__data_out_ready == 1) && (req != 0).
- oa__data_in_ready[g] = 1 only when load is true and i__clear_all is 0. All other bits are 0.
- On load:
  - The output register captures ia__data_in[g], sets src = g and valid = 1.
  - r__ptr becomes g+1, or 0 if g == NUM_INPUTS-1.
- Drain without refill: when the downstream accepts (i__data_out_ready == 1 while o__data_out_valid == 1) and there is no load, valid clears. Data and src hold their values.
- No load: r__ptr holds its value.
- Simultaneous drain and load: the output register is refilled in the same cycle, so no bubble is inserted.
- Index arithmetic: r__ptr never holds a value ≥ NUM_INPUTS. Wrap-around is an explicit compare, not a power-of-two truncation.
- i__clear_all == 1:
  - o__data_out_valid clears and r__ptr is set to 0.
  - oa__data_in_ready is forced to 0.
  - i__clear_all takes priority over load. Data and src hold their values.
- reset == 1, highest priority:
  - o__data_out_valid = 0, o__data_out = 0, o__data_out_src = 0, r__ptr = 0.
  - oa__data_in_ready is forced to all zeros combinationally while reset is high.
- Combinational path: oa__data_in_ready depends on ia__data_in_valid and i__data_out_ready. The upstream bypass FIFO's valid does not depend on its pop, so no combinational loop is formed.

## Timing
- Latency: input accepted in cycle t → o__data_out_valid = 1 with that payload in cycle t+1.
- Throughput: one word per cycle while the downstream holds ready high.
- Output stability: while o__data_out_valid == 1 and i__data_out_ready == 0, data and src hold their values.
- Fairness: with k inputs continuously requesting, each one is served exactly once every k accepted transfers.
- Disabled inputs: changing ia__input_enable takes effect in the same cycle. A disabled input with valid high is simply not popped.
- First cycle after reset deasserts: the arbiter can accept, and output valid appears the following cycle.

## Structure
- Shared package hycube_arb_pkg:
  - MAX_ARB_INPUTS = 16.
  - Direction index constants DIR_N = 0, DIR_E = 1, DIR_S = 2, DIR_W = 3, DIR_PE = 4.
- Sub-module rr_priority_picker (combinational):
  - Inputs: req and ptr.
  - Outputs: grant_valid and grant_idx.
  - Implementation: double-width masked find-first, so it can be reused by the crossbar config logic.
- Top level: pointer register, output register and ready decode.

## Test plan
- Reset then idle. With reset held for 3 cycles and all inputs valid, the bench sees:
  - oa__data_in_ready = 0 and o__data_out_valid = 0 throughout reset.
  - The first grant goes to input 0, and output 0 appears one cycle after reset deasserts.
- Full contention. With all 5 inputs valid and enabled and downstream ready high:
  - Grants follow 0,1,2,3,4,0,…
  - o__data_out_src matches that sequence, delayed by one cycle.
  - One word is transferred every cycle.
- Backpressure. Downstream ready is held low for 4 cycles with inputs 1 and 3 valid:
  - o__data_out holds the first payload and no further ready pulses occur.
  - After ready rises, input 3 is served next and the refill happens in the same cycle as the drain (no bubble).
- Wrap and sparse requests. Start from pointer = 4 with only inputs 2 and 4 valid:
  - Grant order is 4, 2, 4, 2.
  - The pointer never reaches the value 5.
- Enable mask. ia__input_enable = 5'b10110 with all inputs valid:
  - Only inputs 1, 2 and 4 are ever popped.
  - Inputs 0 and 3 keep oa__data_in_ready = 0.
- Clear mid-stream. Assert i__clear_all while o__data_out_valid = 1 and downstream ready is low:
  - In that cycle no input is popped.
  - Next cycle valid = 0, and the next grant starts from input 0.
